// File: rtl/sa_jtag_pkg.sv
// Shared types and sizing for the fabric-side JTAG data-register access engine.
package sa_jtag_pkg;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int IDX_W   = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        DR_IDLE,
        DR_CAPTURE,
        DR_SHIFT,
        DR_UPDATE,
        DR_RESP
    } dr_state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/sa_jtag_dr_access.sv
// Runs one capture/shift/update sequence on a scan-shared data register per request,
// returning the bits shifted out. All outputs are registered from the next state.
module sa_jtag_dr_access
    import sa_jtag_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               req_capture,
    input  logic [MAX_LEN-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_rdata,
    output logic               dr_sel,
    output logic               dr_shift,
    output logic               dr_clk_en,
    output logic               dr_scanin,
    input  logic               dr_scanout,
    output logic               dr_update
);

    // Handshakes: a request moves on req_valid && req_ready (ready only in IDLE);
    // a response moves on rsp_valid && rsp_ready, and rsp_rdata is held until then.
    dr_state_e          state_q, state_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] wdata_q;
    logic               capture_q;
    logic               accept;
    logic               sel_d, shift_d, clk_en_d, scanin_d, update_d;

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            DR_IDLE: begin
                if (accept) begin
                    state_d = DR_CAPTURE;
                    k_d     = '0;
                end
            end
            DR_CAPTURE: state_d = (len_q != '0) ? DR_SHIFT : DR_UPDATE;
            DR_SHIFT: begin
                if (k_q == len_q - LEN_W'(1)) state_d = DR_UPDATE;
                else                          k_d     = k_q + LEN_W'(1);
            end
            DR_UPDATE: state_d = DR_RESP;
            DR_RESP:   if (rsp_ready) state_d = DR_IDLE;
            default:   state_d = DR_IDLE;
        endcase
    end

    // Output values for the cycle after this edge; capture flag comes straight
    // from the request when the engine is entering CAPTURE.
    always_comb begin
        sel_d    = (state_d == DR_CAPTURE) || (state_d == DR_SHIFT) || (state_d == DR_UPDATE);
        shift_d  = (state_d == DR_SHIFT);
        update_d = (state_d == DR_UPDATE);
        clk_en_d = 1'b0;
        scanin_d = 1'b0;
        if (state_d == DR_CAPTURE) clk_en_d = accept ? req_capture : capture_q;
        if (state_d == DR_SHIFT) begin
            clk_en_d = 1'b1;
            scanin_d = wdata_q[k_d[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DR_IDLE;
            k_q       <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            capture_q <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            dr_sel    <= 1'b0;
            dr_shift  <= 1'b0;
            dr_clk_en <= 1'b0;
            dr_scanin <= 1'b0;
            dr_update <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                len_q     <= clamp_len(req_len);
                wdata_q   <= req_wdata;
                capture_q <= req_capture;
                rsp_rdata <= '0;
            end
            // Scanout reflects Q[0] ahead of the edge that performs shift k.
            if (state_q == DR_SHIFT) rsp_rdata[k_q[IDX_W-1:0]] <= dr_scanout;
            req_ready <= (state_d == DR_IDLE);
            rsp_valid <= (state_d == DR_RESP);
            dr_sel    <= sel_d;
            dr_shift  <= shift_d;
            dr_clk_en <= clk_en_d;
            dr_scanin <= scanin_d;
            dr_update <= update_d;
        end
    end

endmodule

// File: tb/tb_sa_jtag_dr_access.sv
// Directed bench for sa_jtag_dr_access against a behavioural scan register of selectable length.
module tb_sa_jtag_dr_access;
    import sa_jtag_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [LEN_W-1:0]   req_len;
    logic               req_capture;
    logic [MAX_LEN-1:0] req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_rdata;
    logic               dr_sel, dr_shift, dr_clk_en, dr_scanin, dr_scanout, dr_update;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int shift_cnt = 0, update_cnt = 0, rsp_cnt = 0;

    // Scan register model: capture loads d_in, shift moves toward Q[0], scanin enters Q[chain_n-1].
    int           chain_n = 16;
    logic [63:0]  d_in    = '0;
    logic [63:0]  model_q = '0;

    sa_jtag_dr_access dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
        .req_capture(req_capture), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .dr_sel(dr_sel), .dr_shift(dr_shift), .dr_clk_en(dr_clk_en),
        .dr_scanin(dr_scanin), .dr_scanout(dr_scanout), .dr_update(dr_update)
    );

    always #5 clk = ~clk;

    assign dr_scanout = model_q[0];

    always @(posedge clk) begin
        logic [63:0] tmp;
        tmp = model_q;
        if (dr_clk_en) begin
            if (dr_shift) begin
                tmp = model_q >> 1;
                tmp[chain_n-1] = dr_scanin;
                for (int i = chain_n; i < 64; i++) tmp[i] = 1'b0;
            end else begin
                tmp = d_in;
            end
        end
        model_q <= tmp;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dr_shift)  shift_cnt  <= shift_cnt + 1;
        if (dr_update) update_cnt <= update_cnt + 1;
        if (rsp_valid) rsp_cnt    <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the edge count at which the request was accepted.
    task automatic send_req(input int len, input logic cap, input logic [63:0] wd, output int acc);
        int waited;
        req_valid   = 1'b1;
        req_len     = LEN_W'(len);
        req_capture = cap;
        req_wdata   = wd;
        waited = 0;
        while (!req_ready && waited < 200) begin
            step();
            waited++;
        end
        if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
        step();
        acc = cyc;
        req_valid = 1'b0;
    endtask

    // Latency numbers the cycle after edge n as cycle n+1.
    task automatic wait_rsp(input int acc, output int lat);
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) break;
            step();
        end
        if (!rsp_valid) check("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
        lat = cyc - acc + 1;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int acc, lat, s0, u0, r0;
        logic [63:0] held;

        reset = 1'b1; req_valid = 1'b0; req_len = '0; req_capture = 1'b0;
        req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) step();
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_dr_outputs", {59'd0, dr_sel, dr_shift, dr_clk_en, dr_scanin, dr_update}, 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        reset = 1'b0;
        step();

        // 16-bit register, capture then full-length shift
        chain_n = 16; d_in = 64'h1234;
        s0 = shift_cnt; u0 = update_cnt;
        send_req(16, 1'b1, 64'hA5C3, acc);
        wait_rsp(acc, lat);
        check("t1_rdata", rsp_rdata, 64'h1234);
        check("t1_model", model_q, 64'hA5C3);
        check("t1_latency", 64'(lat), 64'd19);
        check("t1_shifts", 64'(shift_cnt - s0), 64'd16);
        check("t1_updates", 64'(update_cnt - u0), 64'd1);
        finish_rsp();
        check("t1_ready_after", 64'(req_ready), 64'd1);

        // Zero length: no shift, update still issued
        s0 = shift_cnt; u0 = update_cnt;
        send_req(0, 1'b1, 64'hFFFF, acc);
        wait_rsp(acc, lat);
        check("t2_rdata", rsp_rdata, 64'd0);
        check("t2_latency", 64'(lat), 64'd3);
        check("t2_shifts", 64'(shift_cnt - s0), 64'd0);
        check("t2_updates", 64'(update_cnt - u0), 64'd1);
        finish_rsp();

        // Over-length request clamps to 64 shifts
        chain_n = 64; d_in = 64'hDEADBEEF_01234567;
        s0 = shift_cnt;
        send_req(MAX_LEN + 5, 1'b1, 64'hFEDCBA98_76543210, acc);
        wait_rsp(acc, lat);
        check("t3_rdata", rsp_rdata, 64'hDEADBEEF_01234567);
        check("t3_model", model_q, 64'hFEDCBA98_76543210);
        check("t3_shifts", 64'(shift_cnt - s0), 64'd64);
        check("t3_latency", 64'(lat), 64'd67);
        finish_rsp();

        // Response held off for 10 cycles while a new request waits
        chain_n = 8; d_in = 64'h5A;
        send_req(4, 1'b1, 64'h0F, acc);
        wait_rsp(acc, lat);
        check("t4_rdata", rsp_rdata, 64'hA);
        held = rsp_rdata;
        req_valid = 1'b1; req_len = LEN_W'(8); req_capture = 1'b1; req_wdata = 64'h77;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_hold_rdata", rsp_rdata, held);
            check("t4_hold_ready", 64'(req_ready), 64'd0);
            check("t4_hold_valid", 64'(rsp_valid), 64'd1);
            check("t4_hold_sel", 64'(dr_sel), 64'd0);
        end
        req_valid = 1'b0;
        check("t4_model", model_q, 64'hF5);
        finish_rsp();
        check("t4_released", 64'(rsp_valid), 64'd0);

        // Reset in the middle of SHIFT at k=5
        chain_n = 16; d_in = 64'hBEEF;
        send_req(16, 1'b1, 64'h1111, acc);
        repeat (5) step();
        check("t5_in_shift", 64'(dr_shift), 64'd1);
        u0 = update_cnt; r0 = rsp_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_dr_outputs", {59'd0, dr_sel, dr_shift, dr_clk_en, dr_scanin, dr_update}, 64'd0);
        check("t5_req_ready", 64'(req_ready), 64'd1);
        repeat (25) step();
        check("t5_no_update", 64'(update_cnt - u0), 64'd0);
        check("t5_no_rsp", 64'(rsp_cnt - r0), 64'd0);

        // Back-to-back, no capture: second read returns the first write
        chain_n = 8;
        send_req(8, 1'b0, 64'h3C, acc);
        wait_rsp(acc, lat);
        finish_rsp();
        send_req(8, 1'b0, 64'hF0, acc);
        wait_rsp(acc, lat);
        check("t6_rdata", rsp_rdata, 64'h3C);
        check("t6_model", model_q, 64'hF0);
        finish_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
